// File: rtl/sfifo_serializer.sv
// Width-down serializer: one WIDTH_IN word in, RATIO WIDTH_OUT beats out (LSB lane first, or MSB first with SFIFO_SERIALIZER_MSB_FIRST_EN).
// Latency: first beat valid 1 cycle after the input handshake; sustained 1 beat per cycle with no inter-word bubble.
// Backpressure: sender_ready low freezes the current beat; receiver_ready only rises when idle or on an accepted last beat.
module sfifo_serializer #(
    parameter int WIDTH_IN  = 32,
    parameter int WIDTH_OUT = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [WIDTH_IN-1:0]  receiver_data,
    input  logic                 receiver_valid,
    output logic                 receiver_ready,
    output logic [WIDTH_OUT-1:0] sender_data,
    output logic                 sender_valid,
    input  logic                 sender_ready
);

    localparam int RATIO  = WIDTH_IN / WIDTH_OUT;
    localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;

    if ((WIDTH_IN % WIDTH_OUT) != 0 || RATIO < 2) begin : g_bad_params
        $error("sfifo_serializer: WIDTH_IN must be a multiple of WIDTH_OUT with ratio >= 2");
    end

    // Output is busy exactly when a beat is being presented.
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [LANE_W-1:0]      lane_q, lane_d;
    logic [WIDTH_IN-1:0]    shreg_q, shreg_d;
    logic [WIDTH_OUT-1:0]   data_q, data_d;

    logic last;
    logic in_fire;
    logic out_fire;

    // Picks lane k out of a word; lane order is the only difference between builds.
    function automatic logic [WIDTH_OUT-1:0] lane_of(input logic [WIDTH_IN-1:0] w,
                                                     input logic [LANE_W-1:0]   k);
`ifdef SFIFO_SERIALIZER_MSB_FIRST_EN
        lane_of = w[WIDTH_IN-1-int'(k)*WIDTH_OUT -: WIDTH_OUT];
`else
        lane_of = w[int'(k)*WIDTH_OUT +: WIDTH_OUT];
`endif
    endfunction

    assign last           = (lane_q == LANE_W'(RATIO-1));
    assign sender_valid   = (state_q == SEND);
    assign sender_data    = data_q;
    assign out_fire       = sender_valid && sender_ready;
    // Depends only on registered state and sender_ready, never on receiver_valid.
    assign receiver_ready = !reset && (!sender_valid || (sender_ready && last));
    assign in_fire        = receiver_valid && receiver_ready;

    // Next-state: a new word wins over lane advance so the last beat hands over without a bubble.
    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        if (in_fire) begin
            shreg_d = receiver_data;
            data_d  = lane_of(receiver_data, '0);
            state_d = SEND;
            lane_d  = '0;
        end else if (out_fire) begin
            if (!last) begin
                lane_d = lane_q + LANE_W'(1);
                data_d = lane_of(shreg_q, lane_q + LANE_W'(1));
            end else begin
                state_d = IDLE;
                lane_d  = '0;
            end
        end
    end

    // State registers; reset discards any partially sent word.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            lane_q  <= '0;
            shreg_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_sfifo_serializer.sv
module tb_sfifo_serializer;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] receiver_data;
    logic        receiver_valid;
    logic        receiver_ready;
    logic [7:0]  sender_data;
    logic        sender_valid;
    logic        sender_ready;

    int checks = 0;
    int errors = 0;

    sfifo_serializer #(.WIDTH_IN(32), .WIDTH_OUT(8)) dut (
        .clock          (clock),
        .reset          (reset),
        .receiver_data  (receiver_data),
        .receiver_valid (receiver_valid),
        .receiver_ready (receiver_ready),
        .sender_data    (sender_data),
        .sender_valid   (sender_valid),
        .sender_ready   (sender_ready)
    );

    always #5 clock = ~clock;

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Byte order for a word as seen on the output, chosen by build.
    function automatic logic [7:0] exp_lane(input logic [31:0] w, input int k);
`ifdef SFIFO_SERIALIZER_MSB_FIRST_EN
        exp_lane = w[31-k*8 -: 8];
`else
        exp_lane = w[k*8 +: 8];
`endif
    endfunction

    task automatic test_reset();
        reset = 1'b1; receiver_valid = 1'b0; receiver_data = '0; sender_ready = 1'b1;
        step(); step();
        checks++;
        if (sender_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", sender_valid); end
        checks++;
        if (sender_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", sender_data); end
        checks++;
        if (receiver_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_in_reset got %b want 0", receiver_ready); end
        reset = 1'b0;
        #1;
        checks++;
        if (receiver_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after got %b want 1", receiver_ready); end
    endtask

    task automatic test_single();
        logic [7:0] exp [4];
`ifdef SFIFO_SERIALIZER_MSB_FIRST_EN
        exp = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
`else
        exp = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
`endif
        receiver_data = 32'hAABBCCDD; receiver_valid = 1'b1; sender_ready = 1'b1;
        step();
        receiver_valid = 1'b0; receiver_data = 32'hDEADBEEF;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (sender_valid !== 1'b1 || sender_data !== exp[k]) begin
                errors++; $display("FAIL single_beat%0d got v=%b d=%h want v=1 d=%h", k, sender_valid, sender_data, exp[k]);
            end
            step();
        end
        checks++;
        if (sender_valid !== 1'b0) begin errors++; $display("FAIL single_valid_fall got %b want 0", sender_valid); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [8];
`ifdef SFIFO_SERIALIZER_MSB_FIRST_EN
        exp = '{8'h03, 8'h02, 8'h01, 8'h00, 8'h07, 8'h06, 8'h05, 8'h04};
`else
        exp = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
`endif
        receiver_data = 32'h03020100; receiver_valid = 1'b1; sender_ready = 1'b1;
        step();
        receiver_data = 32'h07060504;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (sender_valid !== 1'b1 || sender_data !== exp[k]) begin
                errors++; $display("FAIL b2b_beat%0d got v=%b d=%h want v=1 d=%h", k, sender_valid, sender_data, exp[k]);
            end
            if (k == 3) begin
                checks++;
                if (receiver_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_last got %b want 1", receiver_ready); end
            end else if (k < 3) begin
                checks++;
                if (receiver_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_mid%0d got %b want 0", k, receiver_ready); end
            end
            step();
            if (k == 3) receiver_valid = 1'b0;
        end
        checks++;
        if (sender_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid_fall got %b want 0", sender_valid); end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp [4];
`ifdef SFIFO_SERIALIZER_MSB_FIRST_EN
        exp = '{8'h44, 8'h33, 8'h22, 8'h11};
`else
        exp = '{8'h11, 8'h22, 8'h33, 8'h44};
`endif
        receiver_data = 32'h44332211; receiver_valid = 1'b1; sender_ready = 1'b1;
        step();
        receiver_valid = 1'b0;
        checks++;
        if (sender_data !== exp[0] || receiver_ready !== 1'b0) begin
            errors++; $display("FAIL bp_beat0 got d=%h rdy=%b want d=%h rdy=0", sender_data, receiver_ready, exp[0]);
        end
        step();
        sender_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (sender_valid !== 1'b1 || sender_data !== exp[1] || receiver_ready !== 1'b0) begin
                errors++; $display("FAIL bp_hold%0d got v=%b d=%h rdy=%b want v=1 d=%h rdy=0",
                                   c, sender_valid, sender_data, receiver_ready, exp[1]);
            end
        end
        sender_ready = 1'b1;
        #1;
        for (int k = 1; k < 4; k++) begin
            checks++;
            if (sender_valid !== 1'b1 || sender_data !== exp[k]) begin
                errors++; $display("FAIL bp_beat%0d got v=%b d=%h want v=1 d=%h", k, sender_valid, sender_data, exp[k]);
            end
            checks++;
            if (receiver_ready !== (k == 3)) begin
                errors++; $display("FAIL bp_ready%0d got %b want %b", k, receiver_ready, (k == 3));
            end
            step();
        end
        checks++;
        if (sender_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_fall got %b want 0", sender_valid); end
    endtask

    task automatic test_reset_mid_word();
        logic [7:0] exp [4];
`ifdef SFIFO_SERIALIZER_MSB_FIRST_EN
        exp = '{8'h88, 8'h77, 8'h66, 8'h55};
`else
        exp = '{8'h55, 8'h66, 8'h77, 8'h88};
`endif
        receiver_data = 32'h44332211; receiver_valid = 1'b1; sender_ready = 1'b1;
        step();
        receiver_valid = 1'b0;
        reset = 1'b1;
        step();
        checks++;
        if (sender_valid !== 1'b0 || sender_data !== 8'h00) begin
            errors++; $display("FAIL rst_mid_state got v=%b d=%h want v=0 d=00", sender_valid, sender_data);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (receiver_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got %b want 1", receiver_ready); end
        receiver_data = 32'h88776655; receiver_valid = 1'b1;
        step();
        receiver_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (sender_valid !== 1'b1 || sender_data !== exp[k]) begin
                errors++; $display("FAIL rst_mid_beat%0d got v=%b d=%h want v=1 d=%h", k, sender_valid, sender_data, exp[k]);
            end
            step();
        end
    endtask

    task automatic test_random_stress();
        logic [7:0]  sb [$];
        logic [31:0] next_word;
        int words_sent = 0;
        int beats_seen = 0;
        int cycles = 0;
        const int n_words = 300;
        next_word = $urandom;
        while ((words_sent < n_words || sb.size() != 0) && cycles < 20000) begin
            receiver_valid = (words_sent < n_words) && ($urandom_range(1) == 1);
            receiver_data  = next_word;
            sender_ready   = ($urandom_range(1) == 1);
            #1;
            if (sender_valid && sender_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL stress_extra_beat got d=%h want no beat", sender_data);
                end else begin
                    if (sender_data !== sb[0]) begin
                        errors++; $display("FAIL stress_beat%0d got %h want %h", beats_seen, sender_data, sb[0]);
                    end
                    void'(sb.pop_front());
                end
                beats_seen++;
            end
            if (receiver_valid && receiver_ready) begin
                for (int k = 0; k < 4; k++) sb.push_back(exp_lane(next_word, k));
                words_sent++;
                next_word = $urandom;
            end
            step();
            cycles++;
        end
        receiver_valid = 1'b0;
        checks++;
        if (beats_seen != n_words * 4 || sb.size() != 0) begin
            errors++; $display("FAIL stress_count got beats=%0d pending=%0d want beats=%0d pending=0",
                               beats_seen, sb.size(), n_words * 4);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_word();
        test_random_stress();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
